tb_mem_delay_model: RTL and testbench



---
 rtl/tb_mem_pkg.sv | 14 +
 rtl/tb_mem_lfsr.sv | 32 +++
 rtl/tb_mem_delay_model.sv | 140 ++++++++++++++
 tb/tb_tb_mem_delay_model.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_mem_pkg.sv
// Shared types and constants for the testharness memory delay model.
package tb_mem_pkg;

  localparam int unsigned RspDataWidth = 64;
  localparam logic [31:0] ErrPattern   = 32'hBADCAB1E;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps     = 16'hB400;

  typedef struct packed {
    logic                    valid;
    logic [RspDataWidth-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/tb_mem_lfsr.sv
// 16-bit Fibonacci LFSR that advances only while enabled; drives random grant stalls.
module tb_mem_lfsr
  import tb_mem_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_d, lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/tb_mem_delay_model.sv
// Simulation memory responder: req/gnt port with fixed response latency, bounded
// outstanding requests and optional pseudo-random grant stalls.
module tb_mem_delay_model
  import tb_mem_pkg::*;
#(
  parameter int unsigned AddrWidth      = 9,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned NumWords       = 256,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          StallEn        = 1'b0,
  parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] strb_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  input  logic                   force_stall_i,
  output logic [31:0]            num_reads_o,
  output logic [31:0]            num_writes_o,
  output logic [15:0]            num_errors_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned ByteOff  = $clog2(NumBytes);
  localparam int unsigned MemIdxW  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned CntW     = $clog2(MaxOutstanding + 1);

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [31:0]          word_idx;
  logic [MemIdxW-1:0]   mem_idx;
  logic                 in_range;
  logic [DataWidth-1:0] rd_word;
  logic [15:0]          lfsr;
  logic                 unused_lfsr;
  logic                 rand_stall;
  logic                 retire;
  logic                 cap_ok;

  rsp_t rsp_d [Latency];
  rsp_t rsp_q [Latency];

  logic [CntW-1:0] out_cnt_d, out_cnt_q;
  logic [31:0]     num_reads_d, num_reads_q;
  logic [31:0]     num_writes_d, num_writes_q;
  logic [15:0]     num_errors_d, num_errors_q;

  assign word_idx = 32'(addr_i >> ByteOff);
  assign mem_idx  = word_idx[MemIdxW-1:0];
  assign in_range = word_idx < NumWords;
  assign rd_word  = in_range ? mem_q[mem_idx] : {(DataWidth/32){ErrPattern}};

  tb_mem_lfsr #(
    .Seed(LfsrSeed)
  ) u_lfsr (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (req_i),
    .lfsr_o(lfsr)
  );

  assign unused_lfsr = ^lfsr[15:2];
  assign rand_stall  = StallEn & (lfsr[1:0] == 2'b00);

  // A retiring response frees its slot in the same cycle, so a full model can still grant.
  assign retire = rsp_q[Latency-1].valid;
  assign cap_ok = (32'(out_cnt_q) < MaxOutstanding) || retire;
  assign gnt_o  = req_i & ~force_stall_i & ~rand_stall & cap_ok;

  always_comb begin
    rsp_d[0].valid = gnt_o;
    rsp_d[0].rdata = (gnt_o && !we_i) ? rd_word : '0;
    for (int s = 1; s < Latency; s++) begin
      rsp_d[s] = rsp_q[s-1];
    end
  end

  always_comb begin
    out_cnt_d    = out_cnt_q;
    num_reads_d  = num_reads_q;
    num_writes_d = num_writes_q;
    num_errors_d = num_errors_q;
    if (gnt_o && !retire) begin
      out_cnt_d = out_cnt_q + CntW'(1);
    end else if (!gnt_o && retire) begin
      out_cnt_d = out_cnt_q - CntW'(1);
    end
    if (gnt_o) begin
      if (we_i) begin
        if (num_writes_q != '1) num_writes_d = num_writes_q + 32'd1;
      end else begin
        if (num_reads_q != '1) num_reads_d = num_reads_q + 32'd1;
      end
      if (!in_range && num_errors_q != '1) begin
        num_errors_d = num_errors_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_q        <= '{default: '0};
      out_cnt_q    <= '0;
      num_reads_q  <= '0;
      num_writes_q <= '0;
      num_errors_q <= '0;
    end else begin
      rsp_q        <= rsp_d;
      out_cnt_q    <= out_cnt_d;
      num_reads_q  <= num_reads_d;
      num_writes_q <= num_writes_d;
      num_errors_q <= num_errors_d;
    end
  end

  // Storage is intentionally never reset; out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (strb_i[b]) begin
          mem_q[mem_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rvalid_o     = rsp_q[Latency-1].valid;
  assign rdata_o      = rsp_q[Latency-1].rdata;
  assign num_reads_o  = num_reads_q;
  assign num_writes_o = num_writes_q;
  assign num_errors_o = num_errors_q;

endmodule

// File: tb/tb_tb_mem_delay_model.sv
// Bench for tb_mem_delay_model: three configurations, a per-cycle reference model
// (queue of expected responses plus a byte-level memory image), vectors and sequences.
module tb_tb_mem_delay_model;

  localparam int  LAT   [3] = '{3, 4, 2};
  localparam int  MAXO  [3] = '{4, 2, 4};
  localparam int  NW    [3] = '{32, 64, 16};
  localparam bit  STALL [3] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [63:0] data;
    logic [63:0] mask;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [63:0] exp_rdata;
    int          exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n  [3];
  logic        req    [3];
  logic        gnt    [3];
  logic        we     [3];
  logic        rvalid [3];
  logic        fstall [3];
  logic [8:0]  addr   [3];
  logic [63:0] wdata  [3];
  logic [63:0] rdata  [3];
  logic [7:0]  strb   [3];
  logic [31:0] nrd    [3];
  logic [31:0] nwr    [3];
  logic [15:0] nerr   [3];

  int nchk  = 0;
  int nfail = 0;

  exp_t        expq   [3][$];
  logic [63:0] mmem   [3][64];
  logic [63:0] mknown [3][64];
  int          mrd  [3];
  int          mwr  [3];
  int          merr [3];
  int          mcyc [3];
  int          elig   = 0;
  int          stalls = 0;

  tb_mem_delay_model #(.AddrWidth(9), .DataWidth(64), .NumWords(32), .Latency(3),
    .MaxOutstanding(4), .StallEn(1'b0), .LfsrSeed(16'hACE1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .wdata_i(wdata[0]), .strb_i(strb[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .force_stall_i(fstall[0]), .num_reads_o(nrd[0]),
    .num_writes_o(nwr[0]), .num_errors_o(nerr[0]));

  tb_mem_delay_model #(.AddrWidth(9), .DataWidth(64), .NumWords(64), .Latency(4),
    .MaxOutstanding(2), .StallEn(1'b0), .LfsrSeed(16'hACE1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .wdata_i(wdata[1]), .strb_i(strb[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .force_stall_i(fstall[1]), .num_reads_o(nrd[1]),
    .num_writes_o(nwr[1]), .num_errors_o(nerr[1]));

  tb_mem_delay_model #(.AddrWidth(9), .DataWidth(64), .NumWords(16), .Latency(2),
    .MaxOutstanding(4), .StallEn(1'b1), .LfsrSeed(16'hACE1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .wdata_i(wdata[2]), .strb_i(strb[2]), .rvalid_o(rvalid[2]),
    .rdata_o(rdata[2]), .force_stall_i(fstall[2]), .num_reads_o(nrd[2]),
    .num_writes_o(nwr[2]), .num_errors_o(nerr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    nchk++;
    if (act !== req_v) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, req_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluated at every falling edge, inputs and outputs are stable.
  exp_t me;
  bit   mok;
  int   midx;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n[i]) begin
        expq[i].delete();
        mrd[i]  = 0;
        mwr[i]  = 0;
        merr[i] = 0;
      end else begin
        mok = req[i] && !fstall[i] && ((expq[i].size() < MAXO[i]) || rvalid[i]);
        if (!STALL[i]) begin
          check("gnt", gnt[i], mok);
        end else begin
          check("gnt_allowed", gnt[i] & ~mok, 1'b0);
          if (mok) begin
            elig++;
            if (!gnt[i]) stalls++;
          end
        end
        if (rvalid[i]) begin
          if (expq[i].size() == 0) begin
            check("rvalid_unexpected", rvalid[i], 1'b0);
          end else begin
            me = expq[i].pop_front();
            check("rsp_rdata", rdata[i] & me.mask, me.data & me.mask);
            check("rsp_latency", mcyc[i] - me.cyc, LAT[i]);
          end
        end else if (expq[i].size() > 0 && mcyc[i] - expq[i][0].cyc >= LAT[i]) begin
          check("rvalid_missing", rvalid[i], 1'b1);
          void'(expq[i].pop_front());
        end
        check("num_reads", nrd[i], mrd[i]);
        check("num_writes", nwr[i], mwr[i]);
        check("num_errors", nerr[i], merr[i]);
        if (gnt[i]) begin
          midx = int'(addr[i]) / 8;
          if (midx >= NW[i]) merr[i]++;
          if (we[i]) begin
            mwr[i]++;
            if (midx < NW[i]) begin
              for (int b = 0; b < 8; b++) begin
                if (strb[i][b]) begin
                  mmem[i][midx][8*b +: 8]   = wdata[i][8*b +: 8];
                  mknown[i][midx][8*b +: 8] = 8'hFF;
                end
              end
            end
            me.data = 64'd0;
            me.mask = '1;
          end else begin
            mrd[i]++;
            if (midx < NW[i]) begin
              me.data = mmem[i][midx];
              me.mask = mknown[i][midx];
            end else begin
              me.data = 64'hBADCAB1E_BADCAB1E;
              me.mask = '1;
            end
          end
          me.cyc = mcyc[i];
          expq[i].push_back(me);
        end
      end
      mcyc[i]++;
    end
  end

  task automatic xact(input int i, input vec_t v, output logic [63:0] rd, output int lat);
    bit got;
    tick();
    req[i] = 1'b1; we[i] = v.we; addr[i] = v.addr; wdata[i] = v.wdata; strb[i] = v.strb;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt[i]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("grant_timeout", got, 1'b1);
    tick();
    req[i] = 1'b0;
    rd = '0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rvalid[i]) begin
        rd = rdata[i];
        lat = n;
        break;
      end
      tick();
    end
  endtask

  vec_t        vt [10];
  logic [63:0] rd;
  int          lat;
  int          got2;
  int          gcnt;
  logic        gpat [12];

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; fstall[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; strb[i] = '0;
      mrd[i] = 0; mwr[i] = 0; merr[i] = 0; mcyc[i] = 0;
      for (int w = 0; w < 64; w++) begin
        mmem[i][w] = '0;
        mknown[i][w] = '0;
      end
    end
    vt[0] = '{1'b1, 9'h010, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 0};
    vt[1] = '{1'b0, 9'h010, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0};
    vt[2] = '{1'b1, 9'h018, 64'h0, 8'hFF, 64'h0, 0};
    vt[3] = '{1'b1, 9'h018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 0};
    vt[4] = '{1'b0, 9'h018, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 0};
    vt[5] = '{1'b1, 9'h000, 64'h1111_1111_1111_1111, 8'hFF, 64'h0, 0};
    vt[6] = '{1'b0, 9'h100, 64'h0, 8'h00, 64'hBADCAB1E_BADCAB1E, 1};
    vt[7] = '{1'b1, 9'h100, 64'h5555_5555_5555_5555, 8'hFF, 64'h0, 2};
    vt[8] = '{1'b0, 9'h000, 64'h0, 8'h00, 64'h1111_1111_1111_1111, 2};
    vt[9] = '{1'b0, 9'h010, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 2};

    repeat (3) tick();
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("reset_rvalid", rvalid[i], 1'b0);
      check("reset_rdata", rdata[i], 64'h0);
      check("reset_num_reads", nrd[i], 32'd0);
      check("reset_num_writes", nwr[i], 32'd0);
      check("reset_num_errors", nerr[i], 16'd0);
    end

    // Directed vectors on the Latency=3, NumWords=32 instance.
    for (int k = 0; k < 10; k++) begin
      xact(0, vt[k], rd, lat);
      check("vec_rdata", rd, vt[k].exp_rdata);
      check("vec_latency", lat, 3);
      check("vec_num_errors", nerr[0], vt[k].exp_err);
    end
    check("vec_num_reads", nrd[0], 32'd5);
    check("vec_num_writes", nwr[0], 32'd5);

    // Write then read of the same word in consecutive cycles.
    tick();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'h020;
    wdata[0] = 64'hA5A5_5A5A_0F0F_F0F0; strb[0] = 8'hFF;
    @(negedge clk);
    check("raw_wr_gnt", gnt[0], 1'b1);
    tick();
    we[0] = 1'b0;
    @(negedge clk);
    check("raw_rd_gnt", gnt[0], 1'b1);
    tick();
    req[0] = 1'b0;
    rd = '0;
    got2 = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rvalid[0]) begin
        got2++;
        if (got2 == 2) begin
          rd = rdata[0];
          break;
        end
      end
      tick();
    end
    check("raw_rdata", rd, 64'hA5A5_5A5A_0F0F_F0F0);

    // Reset with three reads in flight.
    tick();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'h010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_pre_gnt", gnt[0], 1'b1);
      tick();
    end
    req[0] = 1'b0;
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rst_no_rvalid", rvalid[0], 1'b0);
      tick();
    end
    check("rst_num_reads", nrd[0], 32'd0);
    check("rst_num_writes", nwr[0], 32'd0);
    check("rst_num_errors", nerr[0], 16'd0);
    xact(0, vt[9], rd, lat);
    check("post_rst_rdata", rd, 64'h0123_4567_89AB_CDEF);
    check("post_rst_latency", lat, 3);
    check("post_rst_num_reads", nrd[0], 32'd1);

    // Randomised traffic with random force_stall against the model.
    for (int k = 0; k < 300; k++) begin
      tick();
      req[0]    = ($urandom_range(0, 9) < 7);
      we[0]     = 1'($urandom_range(0, 1));
      addr[0]   = 9'($urandom_range(0, 'h13F));
      wdata[0]  = {$urandom, $urandom};
      strb[0]   = 8'($urandom);
      fstall[0] = ($urandom_range(0, 9) == 0);
    end
    tick();
    req[0] = 1'b0; fstall[0] = 1'b0;
    repeat (10) tick();

    // MaxOutstanding=2, Latency=4 with request held high.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'h000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      gpat[k] = gnt[1];
      tick();
    end
    req[1] = 1'b0;
    for (int k = 0; k < 12; k++) check("gnt_pattern", gpat[k], (k % 4) < 2);
    repeat (10) tick();
    check("pattern_num_reads", nrd[1], 32'd6);

    // Random stalls enabled.
    for (int k = 0; k < 1600; k++) begin
      tick();
      req[2]   = ($urandom_range(0, 9) < 8);
      we[2]    = 1'($urandom_range(0, 1));
      addr[2]  = 9'($urandom_range(0, 16*8 + 15));
      wdata[2] = {$urandom, $urandom};
      strb[2]  = 8'($urandom);
    end
    tick();
    req[2] = 1'b0;
    repeat (6) tick();
    $display("stall rate: %0d stalls in %0d eligible cycles", stalls, elig);
    check("stall_rate_20_30pct", (elig > 0) && (stalls * 100 >= elig * 20) &&
          (stalls * 100 <= elig * 30), 1'b1);

    req[2] = 1'b1; fstall[2] = 1'b1;
    gcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (gnt[2]) gcnt++;
      tick();
    end
    req[2] = 1'b0; fstall[2] = 1'b0;
    check("force_stall_grants", gcnt, 0);
    repeat (10) tick();

    for (int i = 0; i < 3; i++) check("all_answered", expq[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", nfail, nchk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
